tx_packet_ctrl: RTL and testbench

USB transmit packet sequencer for the encryptor's transmit path. Accepts a packet request and walks the packet through SYNC, PID, optional DATA, CRC5 or CRC16, and EOP by raising one field-active level at a time. Sits directly upstream of the transmit bit timer: it drives the timer's `*_transmitting` inputs and advances on the timer's one-cycle `*_bits_transmitted` strobes. It generates the EOP signalling itself.

---
 rtl/tx_packet_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tx_packet_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_ctrl.sv
// rtl/tx_packet_ctrl.sv - USB transmit packet sequencer (SYNC/PID/DATA/CRC/EOP)
module tx_packet_ctrl #(
    parameter int unsigned BIT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [1:0] tx_type,
    input  logic       tx_abort,
    input  logic       sync_bits_transmitted,
    input  logic       pid_bits_transmitted,
    input  logic       crc5_bits_transmitted,
    input  logic       crc16_bits_transmitted,
    input  logic       data_bits_transmitted,
    output logic       sync_transmitting,
    output logic       pid_transmitting,
    output logic       crc5_transmitting,
    output logic       crc16_transmitting,
    output logic       data_transmitting,
    output logic       eop_se0,
    output logic       eop_j,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC5,
        CRC16,
        EOP_SE0,
        EOP_J,
        DONE
    } state_t;

    localparam logic [1:0] TYPE_HANDSHAKE = 2'b00;
    localparam logic [1:0] TYPE_TOKEN     = 2'b01;
    localparam logic [1:0] TYPE_RESERVED  = 2'b11;

    // SE0 lasts two bit times, idle J one bit time
    localparam logic [8:0] SE0_LAST = 9'(2 * BIT_CYCLES - 1);
    localparam logic [8:0] J_LAST   = 9'(BIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] type_q, type_d;
    logic [8:0] cnt_q, cnt_d;
    logic       error_d;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = '0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (tx_type == TYPE_RESERVED) begin
                        error_d = 1'b1;
                    end else begin
                        type_d  = tx_type;
                        state_d = SYNC;
                    end
                end
            end
            SYNC: begin
                if (tx_abort) begin
                    state_d = EOP_SE0;
                end else if (sync_bits_transmitted) begin
                    state_d = PID;
                end
            end
            PID: begin
                if (tx_abort) begin
                    state_d = EOP_SE0;
                end else if (pid_bits_transmitted) begin
                    case (type_q)
                        TYPE_HANDSHAKE: state_d = EOP_SE0;
                        TYPE_TOKEN:     state_d = CRC5;
                        default:        state_d = DATA;
                    endcase
                end
            end
            DATA: begin
                if (tx_abort) begin
                    state_d = EOP_SE0;
                end else if (data_bits_transmitted) begin
                    state_d = CRC16;
                end
            end
            CRC5: begin
                if (tx_abort || crc5_bits_transmitted) begin
                    state_d = EOP_SE0;
                end
            end
            CRC16: begin
                if (tx_abort || crc16_bits_transmitted) begin
                    state_d = EOP_SE0;
                end
            end
            EOP_SE0: begin
                if (cnt_q == SE0_LAST) begin
                    state_d = EOP_J;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            EOP_J: begin
                if (cnt_q == J_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q            <= IDLE;
            type_q             <= 2'b00;
            cnt_q              <= '0;
            sync_transmitting  <= 1'b0;
            pid_transmitting   <= 1'b0;
            crc5_transmitting  <= 1'b0;
            crc16_transmitting <= 1'b0;
            data_transmitting  <= 1'b0;
            eop_se0            <= 1'b0;
            eop_j              <= 1'b0;
            tx_busy            <= 1'b0;
            tx_done            <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            state_q            <= state_d;
            type_q             <= type_d;
            cnt_q              <= cnt_d;
            sync_transmitting  <= (state_d == SYNC);
            pid_transmitting   <= (state_d == PID);
            crc5_transmitting  <= (state_d == CRC5);
            crc16_transmitting <= (state_d == CRC16);
            data_transmitting  <= (state_d == DATA);
            eop_se0            <= (state_d == EOP_SE0);
            eop_j              <= (state_d == EOP_J);
            tx_busy            <= (state_d inside {SYNC, PID, DATA, CRC5, CRC16, EOP_SE0, EOP_J});
            tx_done            <= (state_d == DONE);
            tx_error           <= error_d;
        end
    end

    a_one_field_active : assert property (@(posedge clk) disable iff (!n_rst)
        $onehot0({sync_transmitting, pid_transmitting, data_transmitting,
                  crc5_transmitting, crc16_transmitting}));

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// tb/tb_tx_packet_ctrl.sv - scoreboard bench for tx_packet_ctrl
module tb_tx_packet_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [1:0] tx_type;
    logic       tx_abort;
    logic       sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted;
    logic       crc16_bits_transmitted, data_bits_transmitted;
    logic       sync_transmitting, pid_transmitting, crc5_transmitting;
    logic       crc16_transmitting, data_transmitting;
    logic       eop_se0, eop_j, tx_busy, tx_done, tx_error;

    always #5 clk = ~clk;

    tx_packet_ctrl #(.BIT_CYCLES(8)) dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .tx_start               (tx_start),
        .tx_type                (tx_type),
        .tx_abort               (tx_abort),
        .sync_bits_transmitted  (sync_bits_transmitted),
        .pid_bits_transmitted   (pid_bits_transmitted),
        .crc5_bits_transmitted  (crc5_bits_transmitted),
        .crc16_bits_transmitted (crc16_bits_transmitted),
        .data_bits_transmitted  (data_bits_transmitted),
        .sync_transmitting      (sync_transmitting),
        .pid_transmitting       (pid_transmitting),
        .crc5_transmitting      (crc5_transmitting),
        .crc16_transmitting     (crc16_transmitting),
        .data_transmitting      (data_transmitting),
        .eop_se0                (eop_se0),
        .eop_j                  (eop_j),
        .tx_busy                (tx_busy),
        .tx_done                (tx_done),
        .tx_error               (tx_error)
    );

    // Output bit index: 0 sync,1 pid,2 data,3 crc5,4 crc16,5 se0,6 j,7 busy,8 done,9 error
    // Strobe bit index: 0 sync,1 pid,2 data,3 crc5,4 crc16
    localparam int MAXC = 1000;

    int         n_checks = 0;
    int         n_pass   = 0;
    string      tname;
    logic [9:0] exp_q[$];
    int         cyc_q[$];

    int         win_lo[10][2];
    int         win_hi[10][2];
    logic       st_start[MAXC];
    logic [1:0] st_type[MAXC];
    logic       st_abort[MAXC];
    logic [4:0] st_stb[MAXC];
    logic       st_rst[MAXC];

    logic [9:0] mon_exp, mon_act;
    int         mon_cyc;
    logic [9:0] rst_act;
    int         wait_cnt;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_cyc = cyc_q.pop_front();
            mon_act = {tx_error, tx_done, tx_busy, eop_j, eop_se0, crc16_transmitting,
                       crc5_transmitting, data_transmitting, pid_transmitting, sync_transmitting};
            n_checks++;
            if (mon_act === mon_exp) n_pass++;
            else $display("FAIL %s cycle %0d: outputs {err,done,busy,j,se0,crc16,crc5,data,pid,sync} got %b expected %b",
                          tname, mon_cyc, mon_act, mon_exp);
        end
    end

    task automatic clr(input string name);
        tname = name;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 2; k++) begin
                win_lo[i][k] = -1;
                win_hi[i][k] = -2;
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            st_start[c] = 1'b0;
            st_type[c]  = 2'b00;
            st_abort[c] = 1'b0;
            st_stb[c]   = 5'b0;
            st_rst[c]   = 1'b0;
        end
    endtask

    task automatic win(input int idx, input int k, input int lo, input int hi);
        win_lo[idx][k] = lo;
        win_hi[idx][k] = hi;
    endtask

    task automatic start_at(input int c, input logic [1:0] t);
        st_start[c] = 1'b1;
        st_type[c]  = t;
    endtask

    task automatic run(input int ncyc);
        logic [9:0] e;
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            tx_start               = st_start[c];
            tx_type                = st_type[c];
            tx_abort               = st_abort[c];
            sync_bits_transmitted  = st_stb[c][0];
            pid_bits_transmitted   = st_stb[c][1];
            data_bits_transmitted  = st_stb[c][2];
            crc5_bits_transmitted  = st_stb[c][3];
            crc16_bits_transmitted = st_stb[c][4];
            if (!st_rst[c]) n_rst = 1'b1;
            for (int i = 0; i < 10; i++) begin
                e[i] = ((c >= win_lo[i][0]) && (c <= win_hi[i][0])) ||
                       ((c >= win_lo[i][1]) && (c <= win_hi[i][1]));
            end
            exp_q.push_back(e);
            cyc_q.push_back(c);
            if (st_rst[c]) begin
                #2;
                n_rst = 1'b0;
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        tx_start = 1'b0;
        tx_type = 2'b00;
        tx_abort = 1'b0;
        sync_bits_transmitted = 1'b0;
        pid_bits_transmitted = 1'b0;
        crc5_bits_transmitted = 1'b0;
        crc16_bits_transmitted = 1'b0;
        data_bits_transmitted = 1'b0;

        clr("reset");
        st_rst[0] = 1'b1; st_rst[1] = 1'b1; st_rst[2] = 1'b1;
        start_at(1, 2'b00);
        run(4);
        rst_act = {tx_error, tx_done, tx_busy, eop_j, eop_se0, crc16_transmitting,
                   crc5_transmitting, data_transmitting, pid_transmitting, sync_transmitting};
        n_checks++;
        if (rst_act === 10'b0) n_pass++;
        else $display("FAIL reset state: outputs got %b expected all zero", rst_act);

        clr("handshake");
        start_at(0, 2'b00);
        st_stb[20] = 5'b00001;
        st_stb[40] = 5'b00010;
        win(0, 0, 1, 20); win(1, 0, 21, 40); win(5, 0, 41, 56); win(6, 0, 57, 64);
        win(7, 0, 1, 64); win(8, 0, 65, 65);
        run(67);

        clr("data");
        start_at(0, 2'b10);
        st_stb[20] = 5'b00001; st_stb[40] = 5'b00010;
        st_stb[600] = 5'b00100; st_stb[750] = 5'b10000;
        win(0, 0, 1, 20); win(1, 0, 21, 40); win(2, 0, 41, 600); win(4, 0, 601, 750);
        win(5, 0, 751, 766); win(6, 0, 767, 774); win(7, 0, 1, 774); win(8, 0, 775, 775);
        run(777);

        clr("token_stray");
        start_at(0, 2'b01);
        st_stb[10] = 5'b00001;
        st_stb[15] = 5'b00100; st_stb[16] = 5'b10000; st_stb[17] = 5'b01000;
        st_stb[20] = 5'b00010;
        st_stb[25] = 5'b00010; st_stb[26] = 5'b10101;
        st_stb[30] = 5'b01000;
        win(0, 0, 1, 10); win(1, 0, 11, 20); win(3, 0, 21, 30); win(5, 0, 31, 46);
        win(6, 0, 47, 54); win(7, 0, 1, 54); win(8, 0, 55, 55);
        run(57);

        clr("abort");
        start_at(0, 2'b10);
        st_stb[20] = 5'b00001; st_stb[40] = 5'b00010;
        st_stb[300] = 5'b00100; st_abort[300] = 1'b1;
        st_stb[302] = 5'b10000; st_abort[305] = 1'b1; st_abort[327] = 1'b1;
        win(0, 0, 1, 20); win(1, 0, 21, 40); win(2, 0, 41, 300); win(5, 0, 301, 316);
        win(6, 0, 317, 324); win(7, 0, 1, 324); win(8, 0, 325, 325);
        run(330);

        clr("reserved_busy_start");
        start_at(0, 2'b11);
        start_at(3, 2'b00);
        st_stb[8] = 5'b00001;
        start_at(12, 2'b01);
        st_stb[15] = 5'b00010;
        start_at(40, 2'b10);
        start_at(41, 2'b00);
        st_stb[45] = 5'b00001; st_stb[47] = 5'b00010;
        win(9, 0, 1, 1);
        win(0, 0, 4, 8);   win(0, 1, 42, 45);
        win(1, 0, 9, 15);  win(1, 1, 46, 47);
        win(5, 0, 16, 31); win(5, 1, 48, 63);
        win(6, 0, 32, 39); win(6, 1, 64, 71);
        win(7, 0, 4, 39);  win(7, 1, 42, 71);
        win(8, 0, 40, 40); win(8, 1, 72, 72);
        run(75);

        clr("reset_mid_eop");
        start_at(0, 2'b00);
        st_stb[2] = 5'b00001; st_stb[4] = 5'b00010;
        st_rst[9] = 1'b1; st_rst[10] = 1'b1; st_rst[11] = 1'b1;
        start_at(10, 2'b10);
        start_at(13, 2'b00);
        st_stb[15] = 5'b00001; st_stb[16] = 5'b00010;
        win(0, 0, 1, 2);  win(0, 1, 14, 15);
        win(1, 0, 3, 4);  win(1, 1, 16, 16);
        win(5, 0, 5, 8);  win(5, 1, 17, 32);
        win(6, 0, 33, 40);
        win(7, 0, 1, 8);  win(7, 1, 14, 40);
        win(8, 0, 41, 41);
        run(43);

        wait_cnt = 0;
        while ((exp_q.size() > 0) && (wait_cnt < 10)) begin
            @(posedge clk);
            wait_cnt++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL wait expired: %0d expectations still pending", exp_q.size());

        @(posedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
